kbd_ascii_decoder: RTL and testbench
====================================

KBD_ASCII_DECODER -- requirements
Module: kbd_ascii_decoder

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the number of ASCII output FIFO entries (power of two).
REQ-003 Port clk SHALL be an input, 1 bit: the clock; all state SHALL update on its rising edge.
REQ-004 Port clrn SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 Port key_data SHALL be an input, 8 bits: the scan code at the head of the PS/2 receiver FIFO.
REQ-006 Port ready SHALL be an input, 1 bit: high when the PS/2 receiver FIFO is not empty.
REQ-007 Port kbd_rdn SHALL be an output, 1 bit: active-low pop strobe to the PS/2 receiver.
REQ-008 Port ascii_rdn SHALL be an input, 1 bit: active-low pop strobe from the bus.
REQ-009 Port ascii SHALL be an output, 8 bits: the ASCII character at the output FIFO head.
REQ-010 Port ascii_ready SHALL be an output, 1 bit: high when the output FIFO is not empty.
REQ-011 Port ascii_ovf SHALL be an output, 1 bit: sticky flag set when a character is dropped because the output FIFO is full.

Function
REQ-012 The FSM SHALL have three states: IDLE, FETCH and DECODE.
REQ-013 IDLE SHALL go to FETCH when ready=1, and SHALL stay in IDLE otherwise.
REQ-014 In FETCH, kbd_rdn SHALL be 0 for exactly one cycle, key_data SHALL be registered into code_q, and the FSM SHALL go to DECODE.
REQ-015 DECODE SHALL process code_q and return to IDLE, so kbd_rdn is never low in two consecutive cycles.
REQ-016 Code 0xF0 SHALL set brk_q; code 0xE0 SHALL set ext_q; neither SHALL produce output.
REQ-017 Any other code SHALL clear brk_q and ext_q after it is processed.
REQ-018 Codes 0x12 and 0x59 SHALL set shift_l/shift_r on make and clear them on break.
REQ-019 Code 0x58 on make SHALL toggle caps_q; its break SHALL be ignored.
REQ-020 A break code, an ext_q-prefixed code, or an unmapped code SHALL produce no output.
REQ-021 The mapping SHALL cover PS/2 set-2 letters, digits, punctuation, space (0x29→0x20), Enter (0x5A→0x0D), Backspace (0x66→0x08) and Tab (0x0D→0x09).
REQ-022 Letters SHALL be uppercase iff shift XOR caps_q is 1, where shift = shift_l|shift_r.
REQ-023 Non-letters SHALL use the shifted glyph iff shift=1 (e.g. 0x16→'1' 0x31 / '!' 0x21).
REQ-024 A mapped make code SHALL be pushed during DECODE; if the FIFO is full and ascii_rdn=1, the character SHALL be dropped and ascii_ovf set.
REQ-025 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full, with no drop and no ascii_ovf.
REQ-026 A pop with the FIFO empty SHALL be ignored, and the count SHALL not underflow.
REQ-027 ascii SHALL show the FIFO head when ascii_ready=1 and 0x00 otherwise.
REQ-028 ascii_ready SHALL be derived from the registered count.
REQ-029 Latency: with ready first high in IDLE at cycle N, kbd_rdn SHALL be low in N+1, the push SHALL occur in N+2, and ascii_ready SHALL be high in N+3.
REQ-030 The read and write pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-031 With clrn=0, the FSM SHALL be IDLE, kbd_rdn=1, ascii=0x00, ascii_ready=0 and ascii_ovf=0.
REQ-032 With clrn=0, the pointers, count, brk_q, ext_q, shift_l, shift_r, caps_q and code_q SHALL all be 0.
REQ-033 Reset asserted mid-operation, including during FETCH, SHALL abort immediately, discard any pending code, and release kbd_rdn to 1 asynchronously.
REQ-034 ascii_ovf SHALL clear only on reset.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the prefix constants 0xF0/0xE0, the modifier codes 0x12/0x59/0x58, and the FIFO_DEPTH default.
REQ-036 The combinational lookup SHALL be a sub-module scan2ascii (inputs: code[7:0], shift, caps; outputs: ascii[7:0], valid).
REQ-037 The FIFO SHALL be implemented inside the block as a register array.

Verification
REQ-038 Scenario: after reset, ready=1 with key_data 0x1C → one kbd_rdn low pulse, then ascii=0x61 with ascii_ready=1 three cycles after ready.
REQ-039 Scenario: sequence 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C → FIFO holds 'A' 0x41 then 'a' 0x61, and nothing else.
REQ-040 Scenario: 0x58 make, then 0x1C, then 0x16 → 0x41, then 0x31 (caps affects letters only); 0x58 again, then 0x1C → 0x61.
REQ-041 Scenario: 0xE0, 0x75, then 0xF0, 0x5A → no output; a following 0x5A → 0x0D.
REQ-042 Scenario: nine mapped keys with no pops → count=8 and ascii_ovf=1; repeat with ascii_rdn=0 in the ninth push cycle → no drop and ascii_ovf=0.
REQ-043 Scenario: clrn pulsed low during FETCH → kbd_rdn=1 at once, with all outputs and state at their reset values.

Source files
------------

// File: rtl/kbd_ascii_decoder_pkg.sv
// Shared definitions for the PS/2 set-2 keyboard to ASCII decoder:
// FSM state encoding, prefix and modifier scan codes, and the output FIFO
// default depth.
package kbd_ascii_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  localparam int unsigned FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/kbd_ascii_decoder_if.sv
// Bus bundle between the decoder, the PS/2 receiver FIFO and the host bus.
//   key_data    : scan code at the receiver FIFO head
//   ready       : receiver FIFO not empty
//   kbd_rdn     : active-low pop strobe to the receiver
//   ascii_rdn   : active-low pop strobe from the host bus
//   ascii       : character at the output FIFO head (0x00 when empty)
//   ascii_ready : output FIFO not empty
//   ascii_ovf   : sticky overflow flag
// slave  = decoder side, master = environment side.
interface kbd_ascii_decoder_if;
  logic [7:0] key_data;
  logic       ready;
  logic       kbd_rdn;
  logic       ascii_rdn;
  logic [7:0] ascii;
  logic       ascii_ready;
  logic       ascii_ovf;

  modport slave (
    input  key_data, ready, ascii_rdn,
    output kbd_rdn, ascii, ascii_ready, ascii_ovf
  );

  modport master (
    output key_data, ready, ascii_rdn,
    input  kbd_rdn, ascii, ascii_ready, ascii_ovf
  );
endinterface

// File: rtl/kbd_ascii_decoder_scan2ascii.sv
// Combinational PS/2 set-2 make code to ASCII lookup.
//   code  : scan code
//   shift : either shift key held
//   caps  : caps lock active
//   ascii : translated character (0x00 when unmapped)
//   valid : code has a mapping
// Letters are uppercase when shift XOR caps; other glyphs follow shift only.
module scan2ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic       valid
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       letter;

  always_comb begin
    lo     = '0;
    hi     = '0;
    letter = 1'b0;
    valid  = 1'b1;
    case (code)
      8'h1C: {letter, lo, hi} = {1'b1, "a", "A"};
      8'h32: {letter, lo, hi} = {1'b1, "b", "B"};
      8'h21: {letter, lo, hi} = {1'b1, "c", "C"};
      8'h23: {letter, lo, hi} = {1'b1, "d", "D"};
      8'h24: {letter, lo, hi} = {1'b1, "e", "E"};
      8'h2B: {letter, lo, hi} = {1'b1, "f", "F"};
      8'h34: {letter, lo, hi} = {1'b1, "g", "G"};
      8'h33: {letter, lo, hi} = {1'b1, "h", "H"};
      8'h43: {letter, lo, hi} = {1'b1, "i", "I"};
      8'h3B: {letter, lo, hi} = {1'b1, "j", "J"};
      8'h42: {letter, lo, hi} = {1'b1, "k", "K"};
      8'h4B: {letter, lo, hi} = {1'b1, "l", "L"};
      8'h3A: {letter, lo, hi} = {1'b1, "m", "M"};
      8'h31: {letter, lo, hi} = {1'b1, "n", "N"};
      8'h44: {letter, lo, hi} = {1'b1, "o", "O"};
      8'h4D: {letter, lo, hi} = {1'b1, "p", "P"};
      8'h15: {letter, lo, hi} = {1'b1, "q", "Q"};
      8'h2D: {letter, lo, hi} = {1'b1, "r", "R"};
      8'h1B: {letter, lo, hi} = {1'b1, "s", "S"};
      8'h2C: {letter, lo, hi} = {1'b1, "t", "T"};
      8'h3C: {letter, lo, hi} = {1'b1, "u", "U"};
      8'h2A: {letter, lo, hi} = {1'b1, "v", "V"};
      8'h1D: {letter, lo, hi} = {1'b1, "w", "W"};
      8'h22: {letter, lo, hi} = {1'b1, "x", "X"};
      8'h35: {letter, lo, hi} = {1'b1, "y", "Y"};
      8'h1A: {letter, lo, hi} = {1'b1, "z", "Z"};
      8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("};
      8'h45: {lo, hi} = {"0", ")"};
      8'h0E: {lo, hi} = {8'h60, "~"};
      8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"};
      8'h54: {lo, hi} = {"[", "{"};
      8'h5B: {lo, hi} = {"]", "}"};
      8'h5D: {lo, hi} = {8'h5C, "|"};
      8'h4C: {lo, hi} = {";", ":"};
      8'h52: {lo, hi} = {8'h27, 8'h22};
      8'h41: {lo, hi} = {",", "<"};
      8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};
      8'h29: {lo, hi} = {8'h20, 8'h20};
      8'h5A: {lo, hi} = {8'h0D, 8'h0D};
      8'h66: {lo, hi} = {8'h08, 8'h08};
      8'h0D: {lo, hi} = {8'h09, 8'h09};
      default: valid = 1'b0;
    endcase
    ascii = (letter ? (shift ^ caps) : shift) ? hi : lo;
  end

endmodule

// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 keyboard scan code to ASCII decoder with an output FIFO.
//   clk  : clock, rising edge
//   clrn : asynchronous active-low reset
//   bus  : receiver handshake (key_data/ready/kbd_rdn) and host side
//          (ascii_rdn/ascii/ascii_ready/ascii_ovf)
// Pops one scan code per IDLE->FETCH->DECODE pass, tracks break/extended
// prefixes and shift/caps state, and queues translated make codes.
module kbd_ascii_decoder
  import kbd_ascii_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               clrn,
  kbd_ascii_decoder_if.slave bus
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  state_e     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       shift_l_q, shift_l_d;
  logic       shift_r_q, shift_r_d;
  logic       caps_q, caps_d;
  logic       push;

  logic [7:0] s2a_ascii;
  logic       s2a_valid;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          do_push;
  logic          do_pop;
  logic          drop;

  scan2ascii u_scan2ascii (
    .code  (code_q),
    .shift (shift_l_q | shift_r_q),
    .caps  (caps_q),
    .ascii (s2a_ascii),
    .valid (s2a_valid)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      caps_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      caps_q    <= caps_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    caps_d    = caps_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ready) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        code_d  = bus.key_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (code_q == CODE_BREAK) begin
          brk_d = 1'b1;
        end else if (code_q == CODE_EXT) begin
          ext_d = 1'b1;
        end else begin
          // E0-prefixed codes (e.g. the E0 12 "fake shift") never touch
          // modifier state and never produce a character.
          if (!ext_q) begin
            case (code_q)
              CODE_LSHIFT: shift_l_d = !brk_q;
              CODE_RSHIFT: shift_r_d = !brk_q;
              CODE_CAPS:   if (!brk_q) caps_d = !caps_q;
              default:     push = !brk_q && s2a_valid;
            endcase
          end
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // alongside a pop is accepted rather than dropped.
  assign do_pop  = !bus.ascii_rdn && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= s2a_ascii;
  end

  assign bus.kbd_rdn     = (state_q != ST_FETCH);
  assign bus.ascii_ready = (count_q != '0);
  assign bus.ascii       = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.ascii_ovf   = ovf_q;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
module tb_kbd_ascii_decoder;
  import kbd_ascii_decoder_pkg::*;

  logic        clk  = 1'b0;
  logic        clrn = 1'b0;
  int unsigned chk_cnt = 0;
  int unsigned err_cnt = 0;

  always #5 clk = ~clk;

  kbd_ascii_decoder_if bus ();

  kbd_ascii_decoder #(.FIFO_DEPTH(8)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apply_reset();
    bus.ready     = 1'b0;
    bus.ascii_rdn = 1'b1;
    bus.key_data  = 8'h00;
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    check("rst_kbd_rdn", 16'(bus.kbd_rdn), 16'd1);
    check("rst_ascii", 16'(bus.ascii), 16'h00);
    check("rst_ascii_ready", 16'(bus.ascii_ready), 16'd0);
    check("rst_ovf", 16'(bus.ascii_ovf), 16'd0);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  // One receiver transaction; returns on the negedge after the push edge.
  task automatic send_key(input logic [7:0] code, input logic pop_on_push = 1'b0);
    bit seen = 1'b0;
    @(negedge clk);
    bus.key_data = code;
    bus.ready    = 1'b1;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (!bus.kbd_rdn) seen = 1'b1;
    end
    check("kbd_rdn_pulse", 16'(seen), 16'd1);
    @(negedge clk);
    bus.ready     = 1'b0;
    bus.ascii_rdn = ~pop_on_push;
    check("kbd_rdn_single", 16'(bus.kbd_rdn), 16'd1);
    @(negedge clk);
    bus.ascii_rdn = 1'b1;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_rdy"}, 16'(bus.ascii_ready), 16'd1);
    check(tag, 16'(bus.ascii), 16'(exp));
    bus.ascii_rdn = 1'b0;
    @(negedge clk);
    bus.ascii_rdn = 1'b1;
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_rdy"}, 16'(bus.ascii_ready), 16'd0);
    check(tag, 16'(bus.ascii), 16'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keys [9];
    logic [7:0] chrs [9];
    keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    chrs = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};

    apply_reset();

    // Latency: ready high in cycle N
    @(negedge clk);
    bus.key_data = 8'h1C;
    bus.ready    = 1'b1;
    @(negedge clk);
    check("lat_n1_kbd_rdn", 16'(bus.kbd_rdn), 16'd0);
    check("lat_n1_rdy", 16'(bus.ascii_ready), 16'd0);
    @(negedge clk);
    bus.ready = 1'b0;
    check("lat_n2_kbd_rdn", 16'(bus.kbd_rdn), 16'd1);
    check("lat_n2_rdy", 16'(bus.ascii_ready), 16'd0);
    @(negedge clk);
    check("lat_n3_rdy", 16'(bus.ascii_ready), 16'd1);
    check("lat_n3_ascii", 16'(bus.ascii), 16'h61);
    pop_expect("lat_pop", 8'h61);
    expect_empty("lat_empty");

    // Shift make/break around a letter
    send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
    send_key(8'hF0); send_key(8'h12); send_key(8'h1C);
    pop_expect("shift_A", 8'h41);
    pop_expect("shift_a", 8'h61);
    expect_empty("shift_empty");

    // Caps lock: letters only, break ignored, shift XOR caps
    send_key(8'h58); send_key(8'hF0); send_key(8'h58);
    send_key(8'h1C); send_key(8'h16);
    send_key(8'h59); send_key(8'h1C); send_key(8'h16);
    send_key(8'hF0); send_key(8'h59);
    send_key(8'h58); send_key(8'hF0); send_key(8'h58); send_key(8'h1C);
    pop_expect("caps_A", 8'h41);
    pop_expect("caps_1", 8'h31);
    pop_expect("caps_shift_a", 8'h61);
    pop_expect("caps_shift_bang", 8'h21);
    pop_expect("caps_off_a", 8'h61);
    expect_empty("caps_empty");

    // Extended prefix, break of Enter, unmapped code, then specials
    send_key(8'hE0); send_key(8'h75); send_key(8'hF0); send_key(8'h5A);
    send_key(8'hE0); send_key(8'h1C); send_key(8'h76);
    expect_empty("ext_none");
    send_key(8'h5A); send_key(8'h29); send_key(8'h66); send_key(8'h0D);
    send_key(8'h12); send_key(8'h52); send_key(8'hF0); send_key(8'h12);
    send_key(8'h4E);
    pop_expect("enter", 8'h0D);
    pop_expect("space", 8'h20);
    pop_expect("bksp", 8'h08);
    pop_expect("tab", 8'h09);
    pop_expect("dquote", 8'h22);
    pop_expect("minus", 8'h2D);
    expect_empty("spec_empty");

    // Overflow: nine pushes, no pops
    apply_reset();
    for (int i = 0; i < 9; i++) send_key(keys[i]);
    check("ovf_count", 16'(dut.count_q), 16'd8);
    check("ovf_flag", 16'(bus.ascii_ovf), 16'd1);
    for (int i = 0; i < 8; i++) pop_expect("ovf_pop", chrs[i]);
    expect_empty("ovf_drained");
    check("ovf_sticky", 16'(bus.ascii_ovf), 16'd1);

    // Reset during FETCH with modifiers, FIFO and ovf all non-default
    send_key(8'h12); send_key(8'h58); send_key(8'h1C);
    @(negedge clk);
    bus.key_data = 8'h32;
    bus.ready    = 1'b1;
    @(posedge clk);
    #2;
    check("midrst_fetch", 16'(bus.kbd_rdn), 16'd0);
    clrn = 1'b0;
    #1;
    check("midrst_kbd_rdn", 16'(bus.kbd_rdn), 16'd1);
    check("midrst_rdy", 16'(bus.ascii_ready), 16'd0);
    check("midrst_ascii", 16'(bus.ascii), 16'h00);
    check("midrst_ovf", 16'(bus.ascii_ovf), 16'd0);
    check("midrst_state", 16'(dut.state_q), 16'(ST_IDLE));
    check("midrst_code", 16'(dut.code_q), 16'h00);
    check("midrst_shift_l", 16'(dut.shift_l_q), 16'd0);
    check("midrst_caps", 16'(dut.caps_q), 16'd0);
    check("midrst_count", 16'(dut.count_q), 16'd0);
    check("midrst_wr_ptr", 16'(dut.wr_ptr_q), 16'd0);
    check("midrst_rd_ptr", 16'(dut.rd_ptr_q), 16'd0);
    @(negedge clk);
    bus.ready = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    send_key(8'h1C);
    pop_expect("postrst_a", 8'h61);
    expect_empty("postrst_empty");

    // Full FIFO with a pop in the ninth push cycle: no drop
    for (int i = 0; i < 8; i++) send_key(keys[i]);
    check("full_count", 16'(dut.count_q), 16'd8);
    send_key(keys[8], 1'b1);
    check("pushpop_count", 16'(dut.count_q), 16'd8);
    check("pushpop_ovf", 16'(bus.ascii_ovf), 16'd0);
    for (int i = 1; i < 9; i++) pop_expect("pushpop_pop", chrs[i]);
    expect_empty("pushpop_drained");

    // Pop on empty: no underflow
    @(negedge clk);
    bus.ascii_rdn = 1'b0;
    @(negedge clk);
    bus.ascii_rdn = 1'b1;
    check("underflow_count", 16'(dut.count_q), 16'd0);
    expect_empty("underflow");

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
